ssc_mem_responder: RTL and testbench
====================================

Name: ssc_mem_responder

Overview:
- Synthesizable memory responder that sits opposite ssc_top on its memory interface (address / read / write / Write_data / Read_data).
- Replaces the bench-only behavioural memory, so SSC and BIST runs use a real, checkable slave.
- Host side: streaming preload port that fills the array before a sort, and streaming dump port that reads the sorted array back out.
- Control: single 4-state FSM sequencing LOAD → SERVE → DUMP.

Parameters:
- DATA_W, 16, word width; matches Write_data/Read_data.
- ADDR_W, 8, address width.
- DEPTH, 256, number of words; must equal 2**ADDR_W.
- AUTO_DUMP, 1, 1 = enter DUMP automatically on ssc_done; 0 = return to IDLE.

Ports:
- clk  in  1  system clock, all state on rising edge.
- rst  in  1  asynchronous, active-high reset.
- address  in  ADDR_W  SSC access address.
- read  in  1  SSC read strobe.
- write  in  1  SSC write strobe.
- Write_data  in  DATA_W  SSC write data.
- Read_data  out  DATA_W  registered read data to SSC.
- ssc_done  in  1  done from ssc_top (level).
- load_start  in  1  pulse in IDLE begins preload.
- load_valid  in  1  host preload word valid.
- load_data  in  DATA_W  host preload word.
- load_ready  out  1  high in LOAD.
- dump_req  in  1  pulse in IDLE begins manual dump.
- dump_ready  in  1  host accepts dump word.
- dump_valid  out  1  dump word valid.
- dump_data  out  DATA_W  dump word.
- dump_last  out  1  qualifies word index DEPTH-1.
- serving  out  1  high in SERVE.
- access_err  out  1  sticky: SSC read/write seen outside SERVE.

Behaviour:
- Reset (async, any state):
  - FSM → IDLE; load_cnt, dump_cnt = 0.
  - Read_data, dump_data = 0; all 1-bit outputs = 0; access_err cleared.
  - Memory array NOT reset; contents retained.
- States IDLE, LOAD, SERVE, DUMP.
- IDLE:
  - load_start → LOAD.
  - else dump_req → DUMP.
  - load_start has priority if both are high.
- LOAD:
  - load_ready = 1.
  - On load_valid: mem[load_cnt] <= load_data, load_cnt++.
  - Acceptance of word DEPTH-1 → SERVE next cycle; load_cnt wraps to 0.
  - load_valid low: stall, no write.
- SERVE:
  - serving = 1.
  - read: Read_data <= mem[address] at that edge; valid the cycle after the strobe (1-cycle latency). Read_data holds when read is low.
  - write: mem[address] <= Write_data.
  - read && write, same address: read-before-write. Read_data gets the old word; the new word is stored.
  - ssc_done high: no access is performed that cycle; next state DUMP if AUTO_DUMP=1, else IDLE.
- Outside SERVE: read or write high → strobe ignored, memory and Read_data unchanged, access_err <= 1 until reset.
- DUMP:
  - Entry cycle fetches mem[0]; dump_valid rises the next cycle.
  - dump_valid && dump_ready advances dump_cnt; the next word is presented the following cycle (dump_valid low for 1 cycle between words).
  - dump_data stable while dump_valid && !dump_ready.
  - dump_last = dump_valid && dump_cnt == DEPTH-1.
  - Acceptance of last word → IDLE; dump_cnt → 0; dump_valid → 0.
- Reset mid-LOAD or mid-DUMP: transfer abandoned; partially loaded words remain in memory.

Test Plan:
- Reset: assert rst mid-cycle while in LOAD at load_cnt=37 → same-instant FSM IDLE, load_ready=0, Read_data=0, mem[0..36] unchanged afterwards.
- Preload: load words 255..0 with load_valid toggled every other cycle → 256 writes, serving=1 one cycle after word 255, mem[0]=16'd255.
- Read/write in SERVE: read addr 8'h10 → Read_data=16'h00EF next cycle; simultaneous read+write 16'hBEEF to 8'h10 → Read_data=16'h00EF, next read returns 16'hBEEF.
- Auto dump: ssc_done=1 with AUTO_DUMP=1 → DUMP, 256 words out, dump_last only on word 255, FSM IDLE after last accept; with dump_ready held low 5 cycles, dump_data stays constant.
- Access error: write=1 in IDLE to 8'h00 → mem[0] unchanged, access_err=1 and sticky until rst.
- Manual dump/priority: load_start and dump_req same cycle → LOAD; dump_req alone → DUMP with first dump_valid 2 cycles after pulse.

Source files
------------

// File: rtl/ssc_mem_responder_if.sv
// Memory-side bus between ssc_top, the host preload/dump streams and ssc_mem_responder.
// master = SSC + host side, slave = the responder.
interface ssc_mem_responder_if #(
  parameter int DATA_W = 16,
  parameter int ADDR_W = 8
);
  logic [ADDR_W-1:0] address;
  logic              read;
  logic              write;
  logic [DATA_W-1:0] Write_data;
  logic [DATA_W-1:0] Read_data;
  logic              ssc_done;
  logic              load_start;
  logic              load_valid;
  logic [DATA_W-1:0] load_data;
  logic              load_ready;
  logic              dump_req;
  logic              dump_ready;
  logic              dump_valid;
  logic [DATA_W-1:0] dump_data;
  logic              dump_last;
  logic              serving;
  logic              access_err;

  modport master (
    output address, read, write, Write_data, ssc_done,
           load_start, load_valid, load_data, dump_req, dump_ready,
    input  Read_data, load_ready, dump_valid, dump_data, dump_last,
           serving, access_err
  );

  modport slave (
    input  address, read, write, Write_data, ssc_done,
           load_start, load_valid, load_data, dump_req, dump_ready,
    output Read_data, load_ready, dump_valid, dump_data, dump_last,
           serving, access_err
  );
endinterface

// File: rtl/ssc_mem_responder.sv
// Synthesizable memory slave for ssc_top: host preload, SSC read/write service,
// then a streamed dump of the array. DEPTH must equal 2**ADDR_W.
module ssc_mem_responder #(
  parameter int DATA_W    = 16,
  parameter int ADDR_W    = 8,
  parameter int DEPTH     = 256,
  parameter int AUTO_DUMP = 1
) (
  input  logic                  clk,
  input  logic                  rst,
  ssc_mem_responder_if.slave    bus
);

  typedef enum logic [1:0] {IDLE, LOAD, SERVE, DUMP} state_t;

  localparam logic [ADDR_W-1:0] LAST = ADDR_W'(DEPTH - 1);

  state_t            state;
  logic [DATA_W-1:0] mem [DEPTH];
  logic [ADDR_W-1:0] load_cnt;
  logic [ADDR_W-1:0] dump_cnt;
  logic [DATA_W-1:0] read_data;
  logic [DATA_W-1:0] dump_data;
  logic              dump_valid;
  logic              dump_last;
  logic              load_ready;
  logic              serving;
  logic              access_err;

  logic              mem_we;
  logic [ADDR_W-1:0] mem_waddr;
  logic [DATA_W-1:0] mem_wdata;

  // Only one writer per state: host stream in LOAD, SSC in SERVE (not on the done cycle).
  always_comb begin
    // NOTE: defaults first so every path assigns every output -- no latches.
    mem_we    = 1'b0;
    mem_waddr = load_cnt;
    mem_wdata = bus.load_data;
    if (state == LOAD && bus.load_valid) begin
      mem_we = 1'b1;
    end else if (state == SERVE && !bus.ssc_done && bus.write) begin
      mem_we    = 1'b1;
      mem_waddr = bus.address;
      mem_wdata = bus.Write_data;
    end
  end

  // NOTE: the array has no reset so it maps to RAM and survives rst with its contents.
  always_ff @(posedge clk) begin
    if (mem_we) mem[mem_waddr] <= mem_wdata;
  end

  // NOTE: all state below uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= IDLE;
      load_cnt   <= '0;
      dump_cnt   <= '0;
      read_data  <= '0;
      dump_data  <= '0;
      dump_valid <= 1'b0;
      dump_last  <= 1'b0;
      load_ready <= 1'b0;
      serving    <= 1'b0;
      access_err <= 1'b0;
    end else begin
      if (state != SERVE && (bus.read || bus.write)) access_err <= 1'b1;

      case (state)
        IDLE: begin
          if (bus.load_start) begin
            state      <= LOAD;
            load_cnt   <= '0;
            load_ready <= 1'b1;
          end else if (bus.dump_req) begin
            state      <= DUMP;
            dump_cnt   <= '0;
            dump_valid <= 1'b0;
          end
        end

        LOAD: begin
          if (bus.load_valid) begin
            load_cnt <= load_cnt + 1'b1;
            if (load_cnt == LAST) begin
              state      <= SERVE;
              load_ready <= 1'b0;
              serving    <= 1'b1;
            end
          end
        end

        SERVE: begin
          if (bus.ssc_done) begin
            serving  <= 1'b0;
            dump_cnt <= '0;
            state    <= (AUTO_DUMP != 0) ? DUMP : IDLE;
          end else if (bus.read) begin
            // Old word is captured even when a write hits the same address this edge.
            read_data <= mem[bus.address];
          end
        end

        DUMP: begin
          if (dump_valid && bus.dump_ready) begin
            dump_valid <= 1'b0;
            dump_last  <= 1'b0;
            if (dump_cnt == LAST) begin
              state    <= IDLE;
              dump_cnt <= '0;
            end else begin
              dump_cnt <= dump_cnt + 1'b1;
            end
          end else if (!dump_valid) begin
            dump_data  <= mem[dump_cnt];
            dump_valid <= 1'b1;
            dump_last  <= (dump_cnt == LAST);
          end
        end

        default: state <= IDLE;
      endcase
    end
  end

  assign bus.Read_data  = read_data;
  assign bus.dump_data  = dump_data;
  assign bus.dump_valid = dump_valid;
  assign bus.dump_last  = dump_last;
  assign bus.load_ready = load_ready;
  assign bus.serving    = serving;
  assign bus.access_err = access_err;

endmodule

// File: tb/tb_ssc_mem_responder.sv
// Directed bench for ssc_mem_responder: reset, priority, preload, SSC service,
// auto and manual dump, and the sticky access error.
module tb_ssc_mem_responder;

  localparam int DW = 16;
  localparam int AW = 8;
  localparam int N  = 256;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  ssc_mem_responder_if #(.DATA_W(DW), .ADDR_W(AW)) bus ();

  ssc_mem_responder #(.DATA_W(DW), .ADDR_W(AW), .DEPTH(N), .AUTO_DUMP(1)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int errors = 0;
  int checks = 0;

  logic [DW-1:0] exp_mem   [N];
  bit            exp_known [N];

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    bus.address    = '0;
    bus.read       = 1'b0;
    bus.write      = 1'b0;
    bus.Write_data = '0;
    bus.ssc_done   = 1'b0;
    bus.load_start = 1'b0;
    bus.load_valid = 1'b0;
    bus.load_data  = '0;
    bus.dump_req   = 1'b0;
    bus.dump_ready = 1'b0;
  endtask

  // Consumes a full dump; dump_ready must already be driven by the caller.
  task automatic run_dump(input string tag);
    int idx = 0;
    for (int cyc = 0; cyc < 3 * N + 10 && idx < N; cyc++) begin
      if (bus.dump_valid) begin
        if (exp_known[idx]) begin
          checks++;
          if (bus.dump_data !== exp_mem[idx]) begin
            errors++;
            $display("FAIL %s word %0d: got %h expected %h", tag, idx, bus.dump_data, exp_mem[idx]);
          end
        end
        checks++;
        if (bus.dump_last !== (idx == N - 1)) begin
          errors++;
          $display("FAIL %s dump_last at word %0d: got %b", tag, idx, bus.dump_last);
        end
        if (bus.dump_ready) idx++;
      end
      step();
    end
    checks++;
    if (idx != N) begin
      errors++;
      $display("FAIL %s word count: got %0d expected %0d (cycle budget)", tag, idx, N);
    end
    checks++;
    if (bus.dump_valid !== 1'b0) begin
      errors++;
      $display("FAIL %s valid after last: got %b expected 0", tag, bus.dump_valid);
    end
    step();
    checks++;
    if (bus.dump_valid !== 1'b0) begin
      errors++;
      $display("FAIL %s back to idle: dump_valid got %b expected 0", tag, bus.dump_valid);
    end
  endtask

  task automatic test_reset();
    idle_inputs();
    rst = 1'b1;
    repeat (2) step();
    rst = 1'b0;
    step();
    checks++;
    if ({bus.load_ready, bus.serving, bus.dump_valid, bus.dump_last, bus.access_err} !== 5'b0) begin
      errors++;
      $display("FAIL reset flags: got %b expected 00000",
               {bus.load_ready, bus.serving, bus.dump_valid, bus.dump_last, bus.access_err});
    end
    checks++;
    if (bus.Read_data !== 16'h0000 || bus.dump_data !== 16'h0000) begin
      errors++;
      $display("FAIL reset data: Read_data %h dump_data %h expected 0000", bus.Read_data, bus.dump_data);
    end
  endtask

  task automatic test_priority();
    bus.load_start = 1'b1;
    bus.dump_req   = 1'b1;
    step();
    bus.load_start = 1'b0;
    bus.dump_req   = 1'b0;
    checks++;
    if (bus.load_ready !== 1'b1) begin
      errors++;
      $display("FAIL priority load_ready: got %b expected 1", bus.load_ready);
    end
    step();
    checks++;
    if (bus.dump_valid !== 1'b0) begin
      errors++;
      $display("FAIL priority dump_valid: got %b expected 0", bus.dump_valid);
    end
  endtask

  // Already in LOAD from test_priority: write 37 words, then reset mid-cycle.
  task automatic test_reset_mid_load();
    for (int i = 0; i < 37; i++) begin
      bus.load_valid = 1'b1;
      bus.load_data  = 16'h1000 + 16'(i);
      step();
      exp_mem[i]   = 16'h1000 + 16'(i);
      exp_known[i] = 1'b1;
    end
    bus.load_valid = 1'b0;
    #2 rst = 1'b1;
    #1;
    checks++;
    if (bus.load_ready !== 1'b0 || bus.serving !== 1'b0) begin
      errors++;
      $display("FAIL mid-load reset flags: load_ready %b serving %b expected 0 0", bus.load_ready, bus.serving);
    end
    checks++;
    if (bus.Read_data !== 16'h0000) begin
      errors++;
      $display("FAIL mid-load reset Read_data: got %h expected 0000", bus.Read_data);
    end
    step();
    rst = 1'b0;
    step();
  endtask

  task automatic test_manual_dump(input string tag);
    bus.dump_ready = 1'b1;
    bus.dump_req   = 1'b1;
    step();
    bus.dump_req = 1'b0;
    checks++;
    if (bus.dump_valid !== 1'b0) begin
      errors++;
      $display("FAIL %s entry cycle dump_valid: got %b expected 0", tag, bus.dump_valid);
    end
    step();
    checks++;
    if (bus.dump_valid !== 1'b1) begin
      errors++;
      $display("FAIL %s first dump_valid: got %b expected 1", tag, bus.dump_valid);
    end
    run_dump(tag);
    bus.dump_ready = 1'b0;
  endtask

  task automatic test_preload();
    bus.load_start = 1'b1;
    step();
    bus.load_start = 1'b0;
    checks++;
    if (bus.load_ready !== 1'b1) begin
      errors++;
      $display("FAIL preload load_ready: got %b expected 1", bus.load_ready);
    end
    for (int i = 0; i < N; i++) begin
      bus.load_valid = 1'b1;
      bus.load_data  = 16'(N - 1 - i);
      exp_mem[i]     = 16'(N - 1 - i);
      exp_known[i]   = 1'b1;
      if (i == N - 1) begin
        checks++;
        if (bus.serving !== 1'b0) begin
          errors++;
          $display("FAIL preload early serving: got %b expected 0", bus.serving);
        end
      end
      step();
      bus.load_valid = 1'b0;
      if (i < N - 1) step();
    end
    checks++;
    if (bus.serving !== 1'b1 || bus.load_ready !== 1'b0) begin
      errors++;
      $display("FAIL preload end: serving %b load_ready %b expected 1 0", bus.serving, bus.load_ready);
    end
  endtask

  task automatic test_serve_rw();
    bus.address = 8'h10;
    bus.read    = 1'b1;
    step();
    bus.read = 1'b0;
    checks++;
    if (bus.Read_data !== 16'h00EF) begin
      errors++;
      $display("FAIL serve read: got %h expected 00ef", bus.Read_data);
    end
    bus.read       = 1'b1;
    bus.write      = 1'b1;
    bus.Write_data = 16'hBEEF;
    step();
    bus.read  = 1'b0;
    bus.write = 1'b0;
    exp_mem[16] = 16'hBEEF;
    checks++;
    if (bus.Read_data !== 16'h00EF) begin
      errors++;
      $display("FAIL read-before-write: got %h expected 00ef", bus.Read_data);
    end
    bus.address    = 8'h20;
    bus.write      = 1'b1;
    bus.Write_data = 16'h1234;
    step();
    bus.write = 1'b0;
    exp_mem[32] = 16'h1234;
    checks++;
    if (bus.Read_data !== 16'h00EF) begin
      errors++;
      $display("FAIL Read_data hold: got %h expected 00ef", bus.Read_data);
    end
    bus.address = 8'h10;
    bus.read    = 1'b1;
    step();
    bus.read = 1'b0;
    checks++;
    if (bus.Read_data !== 16'hBEEF) begin
      errors++;
      $display("FAIL read after write: got %h expected beef", bus.Read_data);
    end
  endtask

  task automatic test_auto_dump();
    logic [DW-1:0] held;
    bus.dump_ready = 1'b0;
    bus.ssc_done   = 1'b1;
    step();
    bus.ssc_done = 1'b0;
    checks++;
    if (bus.serving !== 1'b0) begin
      errors++;
      $display("FAIL auto dump serving: got %b expected 0", bus.serving);
    end
    step();
    held = bus.dump_data;
    checks++;
    if (bus.dump_valid !== 1'b1 || held !== exp_mem[0]) begin
      errors++;
      $display("FAIL auto dump first word: valid %b data %h expected 1 %h", bus.dump_valid, held, exp_mem[0]);
    end
    for (int k = 0; k < 5; k++) begin
      step();
      checks++;
      if (bus.dump_valid !== 1'b1 || bus.dump_data !== exp_mem[0]) begin
        errors++;
        $display("FAIL stall cycle %0d: valid %b data %h expected 1 %h", k, bus.dump_valid, bus.dump_data, exp_mem[0]);
      end
    end
    bus.dump_ready = 1'b1;
    run_dump("auto_dump");
    bus.dump_ready = 1'b0;
  endtask

  task automatic test_access_err();
    bus.address    = 8'h00;
    bus.write      = 1'b1;
    bus.Write_data = 16'h5A5A;
    step();
    bus.write = 1'b0;
    checks++;
    if (bus.access_err !== 1'b1) begin
      errors++;
      $display("FAIL access_err set: got %b expected 1", bus.access_err);
    end
    bus.address = 8'h20;
    bus.read    = 1'b1;
    step();
    bus.read = 1'b0;
    checks++;
    if (bus.Read_data !== 16'hBEEF) begin
      errors++;
      $display("FAIL idle read ignored: got %h expected beef", bus.Read_data);
    end
    test_manual_dump("err_dump");
    checks++;
    if (bus.access_err !== 1'b1) begin
      errors++;
      $display("FAIL access_err sticky: got %b expected 1", bus.access_err);
    end
    rst = 1'b1;
    step();
    rst = 1'b0;
    step();
    checks++;
    if (bus.access_err !== 1'b0) begin
      errors++;
      $display("FAIL access_err cleared by reset: got %b expected 0", bus.access_err);
    end
  endtask

  initial begin
    for (int i = 0; i < N; i++) begin
      exp_mem[i]   = '0;
      exp_known[i] = 1'b0;
    end
    test_reset();
    test_priority();
    test_reset_mid_load();
    test_manual_dump("manual_dump");
    test_preload();
    test_serve_rw();
    test_auto_dump();
    test_access_err();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
